// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory / load-store unit.
// Holds access-size encodings, FSM state encodings, the store lane-mask
// function, the misalignment check and the load-extension function.
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_HALT  = 2'b01,
      ST_FAULT = 2'b10
   } state_e;

   // Byte lanes touched by an access of the given size at byte offset lo.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SIZE_BYTE: mask = 4'b0001 << lo;
         SIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: mask = 4'b1111;
         default:   mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // Alignment fault, including the reserved size code.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lo[0];
         SIZE_WORD: bad = (lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Select the addressed byte/half of a little-endian word and extend it.
   function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                               input logic        unsigned_ld,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] res;
      sh  = word >> {lo, 3'b000};
      res = word;
      case (size)
         SIZE_BYTE: res = unsigned_ld ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         SIZE_HALF: res = unsigned_ld ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default:   res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Four byte-wide RAM lanes with per-lane write enables.
// Writes and the registered read both happen on the falling clock edge; the
// read returns the contents from before a same-edge write. No reset, so the
// arrays map onto block RAM.
// Ports:
//   clk_i      core clock (falling edge active)
//   re_i       read enable; rdata_o holds its value when low
//   lane_we_i  per-lane write enable, lane 0 = bits [7:0]
//   addr_i     word address
//   wdata_i    write data, lane l taken from bits [8l+7:8l]
//   rdata_o    registered read data
module dmem_bank #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  re_i,
   input  logic [3:0]            lane_we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem_q [Depth];
      logic [7:0] rd_q;

      always_ff @(negedge clk_i) begin
         if (lane_we_i[l]) begin
            mem_q[addr_i] <= wdata_i[8*l +: 8];
         end
         if (re_i) begin
            rd_q <= mem_q[addr_i];
         end
      end

      assign rdata_o[8*l +: 8] = rd_q;
   end

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory with load/store unit for the FPGA MIPS core.
// Byte/half/word accesses with per-lane stores and sign/zero-extended loads,
// misalignment and range faults, and a one-shot PC snapshot on HALT/FAULT.
// All state updates on the falling edge of clock; reset is synchronous,
// active-high. Optional MMIO output register enabled by DMEM_MMIO_EN.
// Ports:
//   clock, reset                 clock and synchronous reset
//   req, write_enable            access request, 1 = store
//   access_size, load_unsigned   size code, zero-extend sub-word loads
//   address, input_data, pc      byte address, store data, core pc
//   program_ended                core end-of-program flag
//   mmio_out                     MMIO register (DMEM_MMIO_EN only)
//   output_data, output_valid    load result, valid after a legal load
//   output_saved_pc              pc captured on HALT/FAULT entry
//   halted, fault, fault_address state flags and faulting address
module data_memory_lsu
   import mips_mem_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          ADDR_WIDTH = 10,
   parameter int unsigned          PC_LIMIT   = 512,
   parameter logic [DATA_WIDTH-1:0] MMIO_BASE = 32'hFFFF_FF00
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  write_enable,
   input  logic [1:0]            access_size,
   input  logic                  load_unsigned,
   input  logic [DATA_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] input_data,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic                  program_ended,
`ifdef DMEM_MMIO_EN
   output logic [DATA_WIDTH-1:0] mmio_out,
`endif
   output logic [DATA_WIDTH-1:0] output_data,
   output logic                  output_valid,
   output logic [DATA_WIDTH-1:0] output_saved_pc,
   output logic                  halted,
   output logic                  fault,
   output logic [DATA_WIDTH-1:0] fault_address
);

   localparam logic [DATA_WIDTH-1:0] PcLimit = DATA_WIDTH'(PC_LIMIT);

   state_e          state_q;
   logic            mmio_hit;
   logic            in_range;
   logic            bad_access;
   logic            run;
   logic            do_access;
   logic            do_load;
   logic            do_store;
   logic            fault_now;
   logic            halt_now;
   logic [3:0]      lane_we;
   logic [31:0]     store_data;
   logic [31:0]     bank_rdata;

   // Captured controls of the last legal load, used to extend the bank output.
   logic [1:0]      ld_size_q;
   logic            ld_uns_q;
   logic [1:0]      ld_lo_q;
   logic            ld_zero_q;  // no load since reset: output_data reads 0
   logic            ld_mmio_q;
   logic [31:0]     mmio_rd_q;
   logic [31:0]     mmio_q;

`ifdef DMEM_MMIO_EN
   assign mmio_hit = (address == MMIO_BASE);
   assign mmio_out = mmio_q;
`else
   logic unused_mmio_base;
   assign unused_mmio_base = ^MMIO_BASE;
   assign mmio_hit         = 1'b0;
`endif

   assign in_range   = (address[DATA_WIDTH-1:ADDR_WIDTH+2] == '0);
   // The MMIO register only accepts whole-word accesses.
   assign bad_access = misaligned(access_size, address[1:0]) |
                       (mmio_hit ? (access_size != SIZE_WORD) : ~in_range);

   assign run       = (state_q == ST_RUN);
   assign do_access = req & run & ~bad_access & ~reset;
   assign do_load   = do_access & ~write_enable;
   assign do_store  = do_access & write_enable;
   assign fault_now = req & run & bad_access;
   assign halt_now  = run & ((pc >= PcLimit) | program_ended);

   always_comb begin
      store_data = input_data;
      case (access_size)
         SIZE_BYTE: store_data = {4{input_data[7:0]}};
         SIZE_HALF: store_data = {2{input_data[15:0]}};
         default:   store_data = input_data;
      endcase
   end

   assign lane_we = (do_store & ~mmio_hit) ? lane_mask(access_size, address[1:0]) : 4'b0000;

   dmem_bank #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bank (
      .clk_i    (clock),
      .re_i     (do_load & ~mmio_hit),
      .lane_we_i(lane_we),
      .addr_i   (address[ADDR_WIDTH+1:2]),
      .wdata_i  (store_data),
      .rdata_o  (bank_rdata)
   );

   always_ff @(negedge clock) begin
      if (reset) begin
         state_q         <= ST_RUN;
         output_valid    <= 1'b0;
         output_saved_pc <= '0;
         fault_address   <= '0;
         ld_size_q       <= SIZE_WORD;
         ld_uns_q        <= 1'b0;
         ld_lo_q         <= 2'b00;
         ld_zero_q       <= 1'b1;
         ld_mmio_q       <= 1'b0;
         mmio_rd_q       <= '0;
         mmio_q          <= '0;
      end else begin
         output_valid <= do_load;
         if (do_load) begin
            ld_size_q <= access_size;
            ld_uns_q  <= load_unsigned;
            ld_lo_q   <= address[1:0];
            ld_zero_q <= 1'b0;
            ld_mmio_q <= mmio_hit;
            mmio_rd_q <= mmio_q;
         end
         if (do_store && mmio_hit) begin
            mmio_q <= input_data;
         end
         case (state_q)
            ST_RUN: begin
               // A fault on the same edge as a halt condition takes priority.
               if (fault_now) begin
                  state_q         <= ST_FAULT;
                  output_saved_pc <= pc;
                  fault_address   <= address;
               end else if (halt_now) begin
                  state_q         <= ST_HALT;
                  output_saved_pc <= pc;
               end
            end
            default: state_q <= state_q;
         endcase
      end
   end

   always_comb begin
      output_data = load_extend(ld_size_q, ld_uns_q, ld_lo_q, bank_rdata);
      if (ld_zero_q) begin
         output_data = '0;
      end else if (ld_mmio_q) begin
         output_data = mmio_rd_q;
      end
   end

   assign halted = (state_q == ST_HALT);
   assign fault  = (state_q == ST_FAULT);

endmodule
